// File: rtl/jamma_pkg.sv
// Shared scan FSM encoding, default timing constants and the layout of the
// debounce vector used by jamma_joy_scan.
package jamma_pkg;

  typedef enum logic [1:0] {
    SEL_A  = 2'd0,
    SAMP_A = 2'd1,
    SEL_B  = 2'd2,
    SAMP_B = 2'd3
  } scan_state_e;

  localparam int DEF_SETTLE_CYC = 4;
  localparam int DEF_DEB_MAX    = 15;
  localparam int DEF_COIN_HOLD  = 8;

  localparam int NUM_JOY  = 8;
  localparam int NUM_COIN = 2;
  localparam int NUM_DEB  = 20;

  // Bit slots inside the 20-bit debounce vector
  localparam int IDX_P1   = 0;
  localparam int IDX_P2   = 8;
  localparam int IDX_COIN = 16;
  localparam int IDX_SVC  = 18;
  localparam int IDX_TEST = 19;

endpackage

// File: rtl/jamma_debounce_bit.sv
// One-bit sampled debouncer: output follows the sample only after DEB_MAX
// consecutive differing samples; any agreeing sample restarts the count.
module jamma_debounce_bit
  import jamma_pkg::*;
#(
  parameter int DEB_MAX = DEF_DEB_MAX
) (
  input  logic pclk,
  input  logic reset,
  input  logic smp_en_i,
  input  logic smp_i,
  output logic deb_o
);

  logic [3:0] cnt_q, cnt_d, inc;
  logic       deb_q, deb_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    inc   = cnt_q + 4'd1;
    if (smp_en_i) begin
      if (smp_i == deb_q) begin
        cnt_d = '0;
      end else if (inc == 4'(DEB_MAX)) begin
        deb_d = smp_i;
        cnt_d = '0;
      end else begin
        cnt_d = inc;
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      deb_q <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/jamma_joy_scan.sv
// JAMMA joystick scanner: alternates JSELECT between players, samples JJOY
// once per half-frame, debounces all 20 inputs and stretches coin pulses.
module jamma_joy_scan
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int DEB_MAX    = DEF_DEB_MAX,
  parameter int COIN_HOLD  = DEF_COIN_HOLD
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic [NUM_JOY-1:0]  JJOY,
  input  logic [NUM_COIN-1:0] JCOIN,
  input  logic                JSERVICE,
  input  logic                JTEST,
  output logic                JSELECT,
  output logic [NUM_JOY-1:0]  joystick1,
  output logic [NUM_JOY-1:0]  joystick2,
  output logic [NUM_COIN-1:0] coin_n,
  output logic                service_n,
  output logic                test_n,
  output logic                frame_tick
);

  scan_state_e state_q, state_d;
  logic [7:0]  settle_q, settle_d;
  logic        jsel_q, jsel_d;
  logic        tick_q;
  logic        smp_a, smp_b;
  logic [3:0]  sync1_q, sync2_q;
  logic [NUM_DEB-1:0] smp, smp_en, deb;
  logic [NUM_COIN-1:0]      coin_prev_q;
  logic [NUM_COIN-1:0][7:0] hold_q, hold_d;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q  <= SEL_A;
      settle_q <= '0;
      jsel_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      jsel_q   <= jsel_d;
      tick_q   <= (state_q == SAMP_B);
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = '0;
    case (state_q)
      SEL_A:  if (settle_q == 8'(SETTLE_CYC - 1)) state_d = SAMP_A;
              else settle_d = settle_q + 8'd1;
      SAMP_A: state_d = SEL_B;
      SEL_B:  if (settle_q == 8'(SETTLE_CYC - 1)) state_d = SAMP_B;
              else settle_d = settle_q + 8'd1;
      SAMP_B: state_d = SEL_A;
      default: state_d = SEL_A;
    endcase
  end

  // JSELECT is registered from the next state so it lines up with state_q
  always_comb begin
    jsel_d = (state_d == SEL_B) || (state_d == SAMP_B);
    smp_a  = (state_q == SAMP_A);
    smp_b  = (state_q == SAMP_B);
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {JTEST, JSERVICE, JCOIN};
      sync2_q <= sync1_q;
    end
  end

  assign smp    = {sync2_q, JJOY, JJOY};
  assign smp_en = {{4{smp_b}}, {NUM_JOY{smp_b}}, {NUM_JOY{smp_a}}};

  for (genvar g = 0; g < NUM_DEB; g++) begin : g_deb
    jamma_debounce_bit #(.DEB_MAX(DEB_MAX)) u_deb (
      .pclk     (pclk),
      .reset    (reset),
      .smp_en_i (smp_en[g]),
      .smp_i    (smp[g]),
      .deb_o    (deb[g])
    );
  end

  // Hold counts whole frames; a fall during an active hold does not reload it
  always_comb begin
    for (int i = 0; i < NUM_COIN; i++) begin
      hold_d[i] = hold_q[i];
      if (coin_prev_q[i] && !deb[IDX_COIN+i] && (hold_q[i] == 8'd0))
        hold_d[i] = 8'(COIN_HOLD);
      else if (smp_b && (hold_q[i] != 8'd0))
        hold_d[i] = hold_q[i] - 8'd1;
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      coin_prev_q <= '1;
      hold_q      <= '0;
    end else begin
      coin_prev_q <= deb[IDX_COIN +: NUM_COIN];
      hold_q      <= hold_d;
    end
  end

  for (genvar c = 0; c < NUM_COIN; c++) begin : g_coin
    assign coin_n[c] = deb[IDX_COIN+c] & (hold_q[c] == 8'd0);
  end

  assign JSELECT    = jsel_q;
  assign frame_tick = tick_q;
  assign joystick1  = deb[IDX_P1 +: NUM_JOY];
  assign joystick2  = deb[IDX_P2 +: NUM_JOY];
  assign service_n  = deb[IDX_SVC];
  assign test_n     = deb[IDX_TEST];

endmodule

// File: doc/jamma_joy_scan.md
JAMMA_JOY_SCAN -- requirements
Module: jamma_joy_scan

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 4, cycles JSELECT is held before each sample (range 1..255).
REQ-002 SHALL have parameter DEB_MAX, default 15, consecutive differing samples needed to accept a new level (range 1..15).
REQ-003 SHALL have parameter COIN_HOLD, default 8, minimum active-low coin pulse width in scan frames (range 1..255).
REQ-004 SHALL have port pclk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port JJOY, input, 8, multiplexed active-low JAMMA joystick and button lines.
REQ-007 SHALL have port JCOIN, input, 2, active-low asynchronous coin switches.
REQ-008 SHALL have port JSERVICE, input, 1, active-low service switch.
REQ-009 SHALL have port JTEST, input, 1, active-low test switch.
REQ-010 SHALL have port JSELECT, output, 1, mux select: 0 selects player 1, 1 selects player 2.
REQ-011 SHALL have port joystick1, output, 8, debounced player-1 bits, active-low.
REQ-012 SHALL have port joystick2, output, 8, debounced player-2 bits, active-low.
REQ-013 SHALL have port coin_n, output, 2, debounced and stretched coin lines, active-low.
REQ-014 SHALL have port service_n, output, 1, debounced service switch, active-low.
REQ-015 SHALL have port test_n, output, 1, debounced test switch, active-low.
REQ-016 SHALL have port frame_tick, output, 1, one-cycle pulse at the end of each scan frame.

Function
REQ-017 SHALL sequence the FSM SEL_A -> SAMP_A -> SEL_B -> SAMP_B -> SEL_A.
REQ-018 SHALL stay in SEL_A and in SEL_B for exactly SETTLE_CYC cycles, and in each SAMP state for exactly 1 cycle, giving a frame of 2*(SETTLE_CYC+1) cycles.
REQ-019 SHALL drive JSELECT registered: 0 in SEL_A/SAMP_A, 1 in SEL_B/SAMP_B; JJOY is captured only in SAMP_A (player 1) or SAMP_B (player 2).
REQ-020 SHALL pass JCOIN, JSERVICE and JTEST through a 2-flop synchronizer and sample them in SAMP_B.
REQ-021 SHALL debounce every bit with a 4-bit counter that advances only on that bit's sample: sample == output clears the counter; sample != output increments it; reaching DEB_MAX loads the output with the sample and clears the counter.
REQ-022 SHALL make a debounced change visible on the output the cycle after the DEB_MAX-th sample, i.e. DEB_MAX frames of latency.
REQ-023 SHALL hold coin_n[i] low for at least COIN_HOLD frames after the debounced coin[i] falls, and for as long as the debounced coin stays low after that.
REQ-024 SHALL ignore a new coin falling edge while that coin's hold is active; the two coins are independent.
REQ-025 SHALL assert frame_tick for the single cycle following SAMP_B.
REQ-026 SHALL NOT change any debounced output because of a glitch shorter than DEB_MAX consecutive samples.

Reset
REQ-027 SHALL, while reset is high, set the state to SEL_A, JSELECT=0, all counters to 0, joystick1=joystick2=8'hFF, coin_n=2'b11, service_n=test_n=1 and frame_tick=0.
REQ-028 SHALL abort a scan in progress on reset and restart at SEL_A with a full SETTLE_CYC once reset is released.

Structure
REQ-029 SHALL place the FSM state encoding and the default parameter constants in a shared package jamma_pkg.
REQ-030 SHALL implement the per-bit debounce in a sub-module jamma_debounce_bit, instantiated 20 times.

Verification
Bench parameters: SETTLE_CYC=4, DEB_MAX=3, COIN_HOLD=8, so one frame is 10 cycles.
REQ-031 SHALL verify free run: JSELECT reads 0 for 5 cycles, then 1 for 5 cycles, and frame_tick pulses every 10 cycles.
REQ-032 SHALL verify player 1 press: JJOY=8'hFE while JSELECT=0 and 8'hFF while JSELECT=1 -> joystick1=8'hFE after the 3rd frame and joystick2 stays 8'hFF.
REQ-033 SHALL verify a glitch: JJOY[0] low for 2 samples then high -> joystick1 stays 8'hFF.
REQ-034 SHALL verify a coin tap: JCOIN[0] low for 3 frames -> coin_n[0] low for exactly 8 frames; a second tap inside that window does not extend it.
REQ-035 SHALL verify reset mid-frame: reset asserted during SEL_B with joystick1=8'hFE -> all outputs go to their reset values immediately and JSELECT=0.
REQ-036 SHALL verify simultaneous events: JSERVICE, JTEST and JCOIN[1] all asserted together -> all three outputs fall on the same cycle after 3 frames.
